// File: rtl/rand_fill_ctrl_if.sv
// Handshake bundle between rand_fill_ctrl, its command source, the LFSR and the board memory.
// master = controller side, slave = environment side.
`timescale 1ns/1ps

interface rand_fill_ctrl_if #(
    parameter int ADDR_W = 12
);
    logic              start;
    logic              abort;
    logic [15:0]       seed;
    logic              busy;
    logic              done;
    logic              load;
    logic [15:0]       lfsr_seed;
    logic [15:0]       lfsr_out;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_data;
    logic              wr_ready;

    modport master (
        input  start, abort, seed, lfsr_out, wr_ready,
        output busy, done, load, lfsr_seed, wr_en, wr_addr, wr_data
    );

    modport slave (
        output start, abort, seed, lfsr_out, wr_ready,
        input  busy, done, load, lfsr_seed, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/rand_fill_ctrl.sv
// Fills CELLS board cells with pseudo-random alive/dead bits drawn from an external LFSR.
// Define RAND_FILL_WARMUP_EN to discard WARMUP LFSR steps between seed load and the first write.
`timescale 1ns/1ps

module rand_fill_ctrl #(
    parameter int         CELLS   = 4096,
    parameter int         ADDR_W  = 12,
    parameter logic [7:0] DENSITY = 8'd64,
    parameter int         WARMUP  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    rand_fill_ctrl_if.master bus
);

`ifdef RAND_FILL_WARMUP_EN
    typedef enum logic [2:0] {IDLE, LOAD, WARM, FILL, DONE} state_e;
    localparam logic [7:0] WARM_LAST = 8'(WARMUP - 1);
`else
    typedef enum logic [2:0] {IDLE, LOAD, FILL, DONE} state_e;
`endif

    localparam logic [ADDR_W-1:0] LAST_ADDR    = ADDR_W'(CELLS - 1);
    localparam logic [15:0]       SEED_DEFAULT = 16'h0001;

    state_e            r_state;
    logic              r_load_cnt;
    logic              r_busy;
    logic              r_done;
    logic              r_load;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_seed;
`ifdef RAND_FILL_WARMUP_EN
    logic [7:0]        r_warm_cnt;
`endif

    logic w_last;
    logic w_unused;

    assign w_last = (r_addr == LAST_ADDR);

    // Only the low byte of the LFSR feeds the density compare.
`ifdef RAND_FILL_WARMUP_EN
    assign w_unused = ^bus.lfsr_out[15:8];
`else
    assign w_unused = ^{bus.lfsr_out[15:8], 8'(WARMUP)};
`endif

    // NOTE: every state register is assigned with <= and reset synchronously inside the same
    // clocked block, so outputs are clean flop decodes and reset acts on exactly one edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_load_cnt <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_load     <= 1'b0;
            r_wr_en    <= 1'b0;
            r_addr     <= '0;
            r_seed     <= SEED_DEFAULT;
`ifdef RAND_FILL_WARMUP_EN
            r_warm_cnt <= 8'd0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_seed     <= (bus.seed == 16'h0000) ? SEED_DEFAULT : bus.seed;
                        r_state    <= LOAD;
                        r_busy     <= 1'b1;
                        r_load     <= 1'b1;
                        r_load_cnt <= 1'b0;
                    end
                end

                LOAD: begin
                    if (bus.abort) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_load  <= 1'b0;
                    end else if (r_load_cnt) begin
                        r_load <= 1'b0;
`ifdef RAND_FILL_WARMUP_EN
                        r_state    <= WARM;
                        r_warm_cnt <= 8'd0;
`else
                        r_state <= FILL;
                        r_wr_en <= 1'b1;
                        r_addr  <= '0;
`endif
                    end else begin
                        r_load_cnt <= 1'b1;
                    end
                end

`ifdef RAND_FILL_WARMUP_EN
                // The LFSR free-runs here; each cycle discards one step.
                WARM: begin
                    if (bus.abort) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_warm_cnt == WARM_LAST) begin
                        r_state <= FILL;
                        r_wr_en <= 1'b1;
                        r_addr  <= '0;
                    end else begin
                        r_warm_cnt <= r_warm_cnt + 8'd1;
                    end
                end
`endif

                // Abort outranks completion even when the last write is accepted this cycle.
                FILL: begin
                    if (bus.abort) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_wr_en <= 1'b0;
                    end else if (bus.wr_ready) begin
                        if (w_last) begin
                            r_state <= DONE;
                            r_wr_en <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_addr <= r_addr + 1'b1;
                        end
                    end
                end

                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_load  <= 1'b0;
                    r_wr_en <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.load      = r_load;
    assign bus.lfsr_seed = r_seed;
    assign bus.wr_en     = r_wr_en;
    assign bus.wr_addr   = r_addr;
    assign bus.wr_data   = (bus.lfsr_out[7:0] < DENSITY);

endmodule

// File: tb/tb_rand_fill_ctrl.sv
// Scoreboard bench for rand_fill_ctrl: stimulus queues expected writes, a monitor checks them.
// Models the external LFSR as a 16-bit Galois register (taps 16'hB400).
`timescale 1ns/1ps

module tb_rand_fill_ctrl;
    localparam int         CELLS   = 4096;
    localparam int         ADDR_W  = 12;
    localparam logic [7:0] DENSITY = 8'd64;
    localparam int         WARMUP  = 16;
`ifdef RAND_FILL_WARMUP_EN
    localparam int EFF_W = WARMUP;
`else
    localparam int EFF_W = 0;
`endif

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              data;
    } wr_t;

    typedef enum {M_NORMAL, M_ABORT, M_RESET} run_mode_e;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] lfsr_q = 16'h0001;
    int          n_checks = 0;
    int          n_fail = 0;
    int          done_cnt = 0;
    wr_t         exp_q[$];

    rand_fill_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    rand_fill_ctrl #(
        .CELLS  (CELLS),
        .ADDR_W (ADDR_W),
        .DENSITY(DENSITY),
        .WARMUP (WARMUP)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.master)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    // External LFSR: loads while load=1, otherwise steps every clock.
    always @(posedge clk) lfsr_q <= bus.load ? bus.lfsr_seed : lfsr_step(lfsr_q);
    assign bus.lfsr_out = lfsr_q;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted write must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.done) done_cnt++;
            if (bus.wr_en && bus.wr_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr %0h with nothing expected at %0t",
                             bus.wr_addr, $time);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
                    check("wr_data", 32'(bus.wr_data), 32'(e.data));
                end
            end
        end
    end

    task automatic run_fill(input logic [15:0] sd, input bit rnd, input run_mode_e mode,
                            input int cut_at);
        logic [15:0] eff_seed;
        logic [15:0] ref_s;
        int n;
        int load_cycles;
        int addr;
        int k;
        int done0;
        bit cut;

        eff_seed = (sd == 16'h0000) ? 16'h0001 : sd;
        done0 = done_cnt;
        bus.wr_ready = 1'b1;
        bus.seed = sd;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.seed = 16'h0000;
        check("busy_after_start", 32'(bus.busy), 32'd1);
        check("lfsr_seed", 32'(bus.lfsr_seed), 32'(eff_seed));

        n = 0;
        load_cycles = 0;
        while (!bus.wr_en && n < 2 + EFF_W + 8) begin
            if (bus.load) load_cycles++;
            tick();
            n++;
        end
        check("first_wr_en_latency", 32'(n), 32'(2 + EFF_W));
        check("load_cycles", 32'(load_cycles), 32'd2);

        ref_s = eff_seed;
        repeat (EFF_W) ref_s = lfsr_step(ref_s);

        addr = 0;
        k = 0;
        cut = 1'b0;
        while (addr < CELLS && !cut && k < 4 * CELLS) begin
            bus.wr_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (mode == M_RESET && addr == cut_at) begin
                bus.wr_ready = 1'b0;
                rst_n = 1'b0;
                cut = 1'b1;
            end
            if (mode == M_NORMAL && k == 300) begin
                bus.start = 1'b1;
                bus.seed = 16'hBEEF;
            end
            if (bus.wr_ready) begin
                exp_q.push_back('{addr: ADDR_W'(addr), data: (ref_s[7:0] < DENSITY)});
                if (mode == M_ABORT && addr == cut_at) begin
                    bus.abort = 1'b1;
                    cut = 1'b1;
                end
                addr++;
            end
            ref_s = lfsr_step(ref_s);
            k++;
            tick();
            bus.start = 1'b0;
            bus.seed = 16'h0000;
            bus.abort = 1'b0;
            rst_n = 1'b1;
        end
        bus.wr_ready = 1'b1;

        if (cut) begin
            check("cut_wr_en", 32'(bus.wr_en), 32'd0);
            check("cut_busy", 32'(bus.busy), 32'd0);
            check("cut_load", 32'(bus.load), 32'd0);
            check("cut_done", 32'(bus.done), 32'd0);
            if (mode == M_RESET) begin
                check("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
                check("rst_lfsr_seed", 32'(bus.lfsr_seed), 32'h0001);
            end
            repeat (20) tick();
            check("cut_busy_stays_low", 32'(bus.busy), 32'd0);
            check("cut_no_done", 32'(done_cnt - done0), 32'd0);
        end else begin
            check("fill_completed", 32'(addr), 32'(CELLS));
            check("lfsr_seed_held", 32'(bus.lfsr_seed), 32'(eff_seed));
            check("done_pulse", 32'(bus.done), 32'd1);
            check("done_busy", 32'(bus.busy), 32'd1);
            check("done_wr_en", 32'(bus.wr_en), 32'd0);
            tick();
            check("idle_done", 32'(bus.done), 32'd0);
            check("idle_busy", 32'(bus.busy), 32'd0);
            check("done_count", 32'(done_cnt - done0), 32'd1);
        end
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.seed = 16'h0000;
        bus.wr_ready = 1'b1;
        repeat (3) tick();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_load", 32'(bus.load), 32'd0);
        check("rst_wr_en", 32'(bus.wr_en), 32'd0);
        check("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
        check("rst_lfsr_seed", 32'(bus.lfsr_seed), 32'h0001);
        rst_n = 1'b1;
        tick();

        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("idle_abort_busy", 32'(bus.busy), 32'd0);
        check("idle_abort_load", 32'(bus.load), 32'd0);

        run_fill(16'h0001, 1'b0, M_NORMAL, 0);
        run_fill(16'h0000, 1'b0, M_NORMAL, 0);
        run_fill(16'hACE1, 1'b1, M_NORMAL, 0);
        run_fill(16'h1234, 1'b0, M_ABORT, 100);
        run_fill(16'h0001, 1'b0, M_NORMAL, 0);
        run_fill(16'h5A5A, 1'b0, M_ABORT, CELLS - 1);
        run_fill(16'h0F0F, 1'b0, M_RESET, 40);
        run_fill(16'h0001, 1'b1, M_NORMAL, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1, "time limit");
    end

endmodule
